// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// The state encoding is also reused by the read-side scheduler.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BURST   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Width of a requester index; at least one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a beat counter that must hold max_burst itself.
  function automatic int cnt_w(input int m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches from last+1, wrapping modulo n_req.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int n_req = 4,
  localparam int IW = idx_w(n_req)
) (
  input  logic [n_req-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             found,
  output logic [IW-1:0]    idx
);

  // First requester after the previous grantee wins.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= n_req; k++) begin
      j = (int'(last) + k) % n_req;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst round-robin arbiter for the async FIFO write port.
// Holds one producer per grant until req_last or max_burst.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int width     = 32,
  parameter int n_req     = 4,
  parameter int max_burst = 16,
  localparam int IW = idx_w(n_req),
  localparam int BW = cnt_w(max_burst)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [n_req-1:0]       req,
  input  logic [n_req-1:0]       req_last,
  input  logic [n_req*width-1:0] req_data,
  output logic [n_req-1:0]       req_ready,
  input  logic                   full,
  input  logic                   alm_full,
  output logic [width-1:0]       wdata,
  output logic                   wrt_enable,
  output logic [IW-1:0]          grant_id,
  output logic                   busy,
  output logic [BW-1:0]          beat_cnt
);

  arb_state_e    state_q;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] last_q;
  logic [BW-1:0] beat_q;
  logic [BW-1:0] beat_d;
  logic          busy_q;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          accept;
  logic          done;

  rr_pick #(
    .n_req(n_req)
  ) u_pick (
    .req  (req),
    .last (last_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // Beat acceptance and the write-port data mux.
  always_comb begin
    accept = (state_q == ST_BURST) && req[grant_q] && !full;
    beat_d = beat_q + BW'(1);
    done   = accept &&
             (req_last[grant_q] || (beat_d == BW'(max_burst)));
    req_ready          = '0;
    req_ready[grant_q] = accept;
    wrt_enable         = accept;
    wdata = req_data[int'(grant_q)*width +: width];
  end

  // Grant FSM: arbitrate, stream the burst, then a release bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(n_req - 1);
      beat_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_found && !alm_full) begin
            grant_q <= pick_idx;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (accept) beat_q <= beat_d;
          if (done) begin
            busy_q  <= 1'b0;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          last_q  <= grant_q;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign beat_cnt = beat_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter.
// Producers are modeled as per-requester beat lists.
module tb_fifo_wr_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int MB = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           full;
  logic           alm_full;
  logic [W-1:0]   wdata;
  logic           wrt_enable;
  logic [1:0]     grant_id;
  logic           busy;
  logic [4:0]     beat_cnt;

  fifo_wr_arbiter #(
    .width    (W),
    .n_req    (N),
    .max_burst(MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .alm_full  (alm_full),
    .wdata     (wdata),
    .wrt_enable(wrt_enable),
    .grant_id  (grant_id),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  logic [32:0] mem [N][32];
  int          hd [N];
  int          tl [N];
  logic [31:0] exp_q [$];
  int          wr_cyc [$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dv(input int i, input int tag, input int k);
    return {8'(i), 8'(tag), 16'(k)};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (hd[i] < tl[i]) begin
        req[i]          = 1'b1;
        req_last[i]     = mem[i][hd[i]][32];
        req_data[i*W+:W] = mem[i][hd[i]][31:0];
      end else begin
        req[i]          = 1'b0;
        req_last[i]     = 1'b0;
        req_data[i*W+:W] = '0;
      end
    end
  endtask

  task automatic load(input int i, input int n,
                      input bit last_each, input int tag);
    for (int k = 0; k < n; k++) begin
      mem[i][tl[i]] = {last_each, dv(i, tag, k)};
      tl[i]++;
    end
    drive();
  endtask

  // One clock: monitor at negedge+1, pop accepted beats after posedge.
  task automatic tick();
    logic [3:0]  acc;
    logic [31:0] e;
    #1;
    acc = req_ready;
    if (wrt_enable) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("wdata", wdata, e);
      chk("ready", req_ready, 4'b0001 << e[25:24]);
      wr_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) hd[i]++;
    cyc++;
    drive();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    full     = 1'b0;
    alm_full = 1'b0;
    do_reset();

    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_wren", wrt_enable, 0);
    chk("rst_ready", req_ready, 0);

    // Fairness: one-beat bursts, grants 0,1,2,3,0.
    load(0, 2, 1'b1, 1);
    for (int i = 1; i < N; i++) load(i, 1, 1'b1, 1);
    for (int i = 0; i < N; i++) exp_q.push_back(dv(i, 1, 0));
    exp_q.push_back(dv(0, 1, 1));
    wr_cyc.delete();
    repeat (16) tick();
    chk("fair_left", exp_q.size(), 0);
    chk("fair_nwr", wr_cyc.size(), 5);
    for (int i = 1; i < wr_cyc.size(); i++)
      chk("fair_gap", wr_cyc[i] - wr_cyc[i-1], 3);
    do_reset();

    // Forced release at max_burst, then re-grant for the tail.
    load(2, 20, 1'b0, 2);
    for (int k = 0; k < 20; k++) exp_q.push_back(dv(2, 2, k));
    repeat (17) tick();
    chk("mb_beat", beat_cnt, 16);
    chk("mb_busy", busy, 0);
    chk("mb_left", exp_q.size(), 4);
    tick();
    chk("mb_idle", busy, 0);
    tick();
    chk("mb_regrant", grant_id, 2);
    chk("mb_rebusy", busy, 1);
    chk("mb_reclr", beat_cnt, 0);
    repeat (4) tick();
    chk("mb_tail", beat_cnt, 4);
    chk("mb_done", exp_q.size(), 0);
    do_reset();

    // Full stall with req_last presented.
    mem[3][0] = {1'b0, dv(3, 3, 0)};
    mem[3][1] = {1'b0, dv(3, 3, 1)};
    mem[3][2] = {1'b1, dv(3, 3, 2)};
    tl[3] = 3;
    drive();
    for (int k = 0; k < 3; k++) exp_q.push_back(dv(3, 3, k));
    repeat (3) tick();
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("st_wren", wrt_enable, 0);
      chk("st_busy", busy, 1);
      tick();
    end
    chk("st_grant", grant_id, 3);
    full = 1'b0;
    #1;
    chk("st_last_wr", wrt_enable, 1);
    tick();
    chk("st_rel", busy, 0);
    chk("st_beat", beat_cnt, 3);
    chk("st_done", exp_q.size(), 0);
    do_reset();

    // Almost-full blocks a new grant in IDLE.
    alm_full = 1'b1;
    load(0, 1, 1'b1, 4);
    load(1, 1, 1'b1, 4);
    exp_q.push_back(dv(0, 4, 0));
    exp_q.push_back(dv(1, 4, 0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("af_busy", busy, 0);
    end
    alm_full = 1'b0;
    tick();
    chk("af_busy1", busy, 1);
    chk("af_grant", grant_id, 0);
    repeat (6) tick();
    chk("af_done", exp_q.size(), 0);
    do_reset();

    // Reset during beat 3 of a requester-1 burst.
    load(1, 5, 1'b0, 5);
    exp_q.push_back(dv(1, 5, 0));
    exp_q.push_back(dv(1, 5, 1));
    repeat (3) tick();
    chk("mr_beat", beat_cnt, 2);
    #1;
    chk("mr_wren_pre", wrt_enable, 1);
    reset = 1'b1;
    #1;
    chk("mr_wren", wrt_enable, 0);
    chk("mr_ready", req_ready, 0);
    chk("mr_busy", busy, 0);
    chk("mr_beat0", beat_cnt, 0);
    chk("mr_grant", grant_id, 0);
    chk("mr_sb", exp_q.size(), 0);
    do_reset();
    for (int i = 0; i < N; i++) begin
      load(i, 1, 1'b1, 6);
      exp_q.push_back(dv(i, 6, 0));
    end
    tick();
    chk("mr_first", grant_id, 0);
    chk("mr_busy1", busy, 1);
    repeat (12) tick();
    chk("mr_done", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the asynchronous FIFO's single write port among `n_req` producers in the write clock domain. Grants are burst-oriented: a producer holds the port until it signals its last beat or hits `max_burst` beats. It drives the FIFO's `wdata` and `wrt_enable` directly and consumes `full` and `alm_full` as backpressure. It sits between the producers and the FIFO top and has no read-side logic.

## Interface
- `width`, 32: data width; must match the FIFO `width`.
- `n_req`, 4: number of requesters, 2..8.
- `max_burst`, 16: maximum beats per grant, 1..256.
- `clk` input 1: write-domain clock; the same clock as the FIFO `clk_w`.
- `reset` input 1: reset. **One clock; reset is asynchronous and active-high.**
- `req` input `n_req`: per-requester valid.
- `req_last` input `n_req`: the beat presented by requester i is the last of its burst.
- `req_data` input `n_req*width`: packed data; requester i occupies bits `[i*width +: width]`.
- `req_ready` output `n_req`: the beat from requester i is accepted this cycle.
- `full` input 1: FIFO full.
- `alm_full` input 1: FIFO almost full.
- `wdata` output `width`: FIFO write data.
- `wrt_enable` output 1: FIFO write strobe.
- `grant_id` output `$clog2(n_req)`: current or most recent grantee.
- `busy` output 1: high in BURST.
- `beat_cnt` output `$clog2(max_burst)+1`: beats accepted in the current burst.

## Operation
- **FSM states:** IDLE, BURST, RELEASE.
- **IDLE:** if `|req && !alm_full`, pick the winner by round-robin and go to BURST.
  - Search starts at `last_grant+1` and wraps modulo `n_req`.
  - Register `grant_id` = winner and clear `beat_cnt`.
  - If `alm_full` is high, no new burst starts, even with requests pending.
- **BURST:**
  - `req_ready[grant_id] = req[grant_id] && !full`. All other `req_ready` bits are 0.
  - `wrt_enable = req_ready[grant_id]`. `wdata` = the `grant_id` slice of `req_data` (mux, not registered).
  - `beat_cnt` increments on each accepted beat.
  - Go to RELEASE when either:
    - an accepted beat has `req_last[grant_id]=1`, or
    - an accepted beat brings `beat_cnt` to `max_burst`.
- **Backpressure and gaps:**
  - `full` high stalls the burst with the grant held. `alm_full` does not interrupt a burst in progress.
  - `req[grant_id]` low mid-burst is a bubble: no write, grant held, no timeout.
- **RELEASE:** one-cycle bubble. `last_grant <= grant_id`, then go to IDLE.
- **Wrap-around:** a forced release at `max_burst` without `req_last` is legal. The requester re-arbitrates for the rest of its data.
- **Simultaneous events:**
  - `req_last` and `full` in the same cycle: the beat is not accepted and the state is unchanged.
  - A new request arriving during BURST or RELEASE waits for IDLE.
- **Reset:** asserting `reset` at any time, including mid-burst, immediately forces the following:
  - state IDLE;
  - `last_grant = n_req-1`, so requester 0 has first priority;
  - `grant_id=0`, `beat_cnt=0`, `busy=0`;
  - `req_ready=0`, `wrt_enable=0`.

  `wdata` reads the `req_data` slice 0. A partially written burst stays in the FIFO; the arbiter does not track or recover it.

## Timing
- Arbitration latency: `req` rising in IDLE gives the first possible `req_ready` one cycle later.
- Throughput: one beat per cycle inside a burst. Overhead per grant is two idle cycles on the port: the IDLE decision cycle plus RELEASE.
- `wrt_enable`, `wdata` and `req_ready` are combinational from registered state plus `req`, `full` and `req_data`. There is no combinational path from `alm_full` to outputs.
- `full` and `alm_full` are sampled in `clk`. They are FIFO write-domain flags and need no synchronizer.

## Structure
- **Shared package `fifo_arb_pkg`:**
  - state encoding constants `ST_IDLE=2'd0`, `ST_BURST=2'd1`, `ST_RELEASE=2'd2`;
  - a `clog2`-based width helper for `grant_id` and `beat_cnt`.
- **Sub-module `rr_pick`:** combinational round-robin picker.
  - Inputs: `req[n_req-1:0]` and `last[$clog2(n_req)-1:0]`.
  - Outputs: `found` and `idx`.
  - Reused later for a read-side scheduler.
- The top holds the FSM, the counter and the data mux.

## Test plan
- **Fairness:** reset, then all four `req` high continuously with `req_last` on every beat. Grants go 0,1,2,3,0. Each produces one `wrt_enable` pulse; pulses are 3 cycles apart.
- **Forced release:** requester 2 alone with 20 beats, no `req_last`, `max_burst=16`. The grant releases after 16 writes, with `beat_cnt` reaching 16. It re-grants to 2 after the bubble and the remaining 4 beats follow.
- **Full stall:** `full` held high for 5 cycles mid-burst with `req_last` presented. `wrt_enable=0` and the grant is held for those 5 cycles. The last beat is written in the cycle `full` drops, then RELEASE.
- **Almost-full gate:** `alm_full=1` in IDLE with `req=4'b0011`. No grant and `busy=0`. After `alm_full` falls, grant 0 the next cycle.
- **Reset mid-burst:** `reset` pulsed during beat 3 of a requester-1 burst. `wrt_enable`, `req_ready` and `busy` go low at once. After release, with all requesters requesting, requester 0 wins first.
